// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller:
// FSM states, datapath widths and the per-step partial-product shift table.
package mult_pkg;

    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned PRODUCT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Indexed by step: lo*lo, lo*hi, hi*lo, hi*hi.
    localparam logic [3:0] STEP_SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

endpackage

// File: rtl/array_mult_structural.sv
// Combinational 4x4 unsigned array multiplier: an AND plane of partial
// products summed row by row into an 8-bit result.
module array_mult_structural (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] row [4];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            row[i] = {4'b0000, a & {4{b[i]}}} << i;
        end
        p = row[0] + row[1] + row[2] + row[3];
    end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequencing controller: computes an unsigned 8x8 product in four steps by
// driving nibble pairs through one shared 4x4 multiplier and shift-accumulating.
module mult8_seq_ctrl
    import mult_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_a,
    input  logic [OPERAND_W-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRODUCT_W-1:0] out_p,
    output logic                 busy,
    output logic [7:0]           op_count
);

    state_t                 state;
    state_t                 state_next;
    logic [1:0]             step;
    logic [OPERAND_W-1:0]   op_a;
    logic [OPERAND_W-1:0]   op_b;
    logic [PRODUCT_W-1:0]   acc;
    logic [NIBBLE_W-1:0]    nib_a;
    logic [NIBBLE_W-1:0]    nib_b;
    logic [2*NIBBLE_W-1:0]  pp;
    logic                   accept;
    logic                   zero_op;

    // step[1] picks the high nibble of a, step[0] the high nibble of b.
    assign nib_a = step[1] ? op_a[7:4] : op_a[3:0];
    assign nib_b = step[0] ? op_b[7:4] : op_b[3:0];

    array_mult_structural u_mult (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        accept     = 1'b0;
        zero_op    = ZERO_SKIP && ((in_a == '0) || (in_b == '0));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = zero_op ? DONE : CALC;
                end
            end
            CALC: begin
                if (step == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a <= in_a;
                        op_b <= in_b;
                        acc  <= '0;
                        step <= '0;
                    end
                end
                CALC: begin
                    acc  <= acc + (PRODUCT_W'(pp) << STEP_SHIFT[step]);
                    step <= step + 2'd1;
                end
                DONE: begin
                    if (out_ready) begin
                        op_count <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_p = acc;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: directed corners plus random
// operands against a plain-arithmetic reference, on both ZERO_SKIP settings.
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        nz_in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_ready;

    logic        in_ready,   nz_in_ready;
    logic        out_valid,  nz_out_valid;
    logic [15:0] out_p,      nz_out_p;
    logic        busy,       nz_busy;
    logic [7:0]  op_count,   nz_op_count;

    logic        use_nz;
    logic        obs_in_ready, obs_out_valid, obs_busy;
    logic [15:0] obs_out_p;
    logic [7:0]  obs_op_count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned exp_count [2];

    always #5 clk = ~clk;

    mult8_seq_ctrl #(.ZERO_SKIP(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .op_count  (op_count)
    );

    mult8_seq_ctrl #(.ZERO_SKIP(1'b0)) dut_nz (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (nz_in_valid),
        .in_ready  (nz_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (nz_out_valid),
        .out_ready (out_ready),
        .out_p     (nz_out_p),
        .busy      (nz_busy),
        .op_count  (nz_op_count)
    );

    assign obs_in_ready  = use_nz ? nz_in_ready  : in_ready;
    assign obs_out_valid = use_nz ? nz_out_valid : out_valid;
    assign obs_out_p     = use_nz ? nz_out_p     : out_p;
    assign obs_busy      = use_nz ? nz_busy      : busy;
    assign obs_op_count  = use_nz ? nz_op_count  : op_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic v);
        if (use_nz) nz_in_valid = v;
        else        in_valid    = v;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".in_ready"},  32'(obs_in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(obs_out_valid), 32'd0);
        check({tag, ".out_p"},     32'(obs_out_p),     32'd0);
        check({tag, ".busy"},      32'(obs_busy),      32'd0);
        check({tag, ".op_count"},  32'(obs_op_count),  32'd0);
    endtask

    // One full transaction: handshake, latency/result check, optional
    // backpressure with noise on the input side, then the output handshake.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input bit nz, input int unsigned stall);
        int unsigned lat;
        int unsigned exp_lat;
        int unsigned exp_p;
        use_nz    = nz;
        exp_p     = int'(a) * int'(b);
        exp_lat   = (!nz && (a == 0 || b == 0)) ? 1 : 5;
        in_a      = a;
        in_b      = b;
        out_ready = (stall == 0);
        check("in_ready_idle", 32'(obs_in_ready), 32'd1);
        set_valid(1'b1);
        tick();
        set_valid(1'b0);
        lat = 1;
        while (!obs_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
        check("out_p", 32'(obs_out_p), exp_p);
        for (int unsigned i = 0; i < stall; i++) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            set_valid(1'($urandom));
            tick();
            check("stall.out_valid", 32'(obs_out_valid), 32'd1);
            check("stall.out_p",     32'(obs_out_p),     exp_p);
            check("stall.in_ready",  32'(obs_in_ready),  32'd0);
        end
        set_valid(1'b0);
        out_ready = 1'b1;
        tick();
        exp_count[nz] = (exp_count[nz] + 1) % 256;
        check("op_count",       32'(obs_op_count),  exp_count[nz]);
        check("post.out_valid", 32'(obs_out_valid), 32'd0);
        check("post.busy",      32'(obs_busy),      32'd0);
    endtask

    initial begin
        int unsigned seen;
        logic [7:0]  ra;
        logic [7:0]  rb;
        rst          = 1'b1;
        in_valid     = 1'b0;
        nz_in_valid  = 1'b0;
        out_ready    = 1'b0;
        in_a         = '0;
        in_b         = '0;
        use_nz       = 1'b0;
        exp_count[0] = 0;
        exp_count[1] = 0;

        // Reset with random input activity
        for (int i = 0; i < 2; i++) begin
            in_valid    = 1'($urandom);
            nz_in_valid = 1'($urandom);
            out_ready   = 1'($urandom);
            in_a        = 8'($urandom);
            in_b        = 8'($urandom);
            tick();
        end
        use_nz = 1'b0; check_idle_reset("reset");
        use_nz = 1'b1; check_idle_reset("reset_nz");
        rst         = 1'b0;
        in_valid    = 1'b0;
        nz_in_valid = 1'b0;

        // Basic and corner operands
        do_op(8'd13,  8'd11,  1'b0, 0);
        do_op(8'd255, 8'd255, 1'b0, 0);
        do_op(8'd16,  8'd16,  1'b0, 0);
        do_op(8'd15,  8'd15,  1'b0, 0);
        do_op(8'd240, 8'd15,  1'b0, 0);

        // Zero skip on / off
        do_op(8'd0, 8'd200, 1'b0, 0);
        do_op(8'd0, 8'd200, 1'b1, 0);
        do_op(8'd255, 8'd0, 1'b1, 0);

        // Backpressure with input noise
        do_op(8'd7, 8'd9, 1'b0, 3);

        // Reset in cycle 2 of 100*100
        use_nz    = 1'b0;
        in_a      = 8'd100;
        in_b      = 8'd100;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_idle_reset("midreset");
        rst = 1'b0;
        exp_count[0] = 0;
        exp_count[1] = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midreset.no_out", seen, 0);
        do_op(8'd3, 8'd5, 1'b0, 0);

        // Random operands, both variants, random stalls
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            do_op(ra, rb, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        // Counter wrap: 256 products from a fresh reset return op_count to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count[0] = 0;
        exp_count[1] = 0;
        for (int i = 0; i < 256; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'b0, 0);
        end
        use_nz = 1'b0;
        check("wrap.op_count", 32'(op_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult8_seq_ctrl.md
# mult8_seq_ctrl

Sequencing controller that turns the team's single combinational 4x4 array multiplier into an unsigned 8x8 multiplier. It splits each operand into nibbles, drives the four nibble products through the one multiplier instance on successive clocks, and shift-accumulates them into a 16-bit result. It sits between the chip top-level wrapper (operand capture from input pins) and the multiplier datapath, with valid/ready handshakes on both sides.

## Interface
- ZERO_SKIP, default 1: when 1, an operand pair with either value zero bypasses the CALC steps and completes with product 0.
- clk  input  1  system clock, rising-edge. Single clock domain.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair present.
- in_ready  output  1  controller can accept an operand pair.
- in_a  input  8  multiplicand, unsigned.
- in_b  input  8  multiplier, unsigned.
- out_valid  output  1  product available.
- out_ready  input  1  consumer takes the product.
- out_p  output  16  product in_a*in_b, unsigned.
- busy  output  1  state is not IDLE.
- op_count  output  8  completed-product counter.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_a/in_b into operand registers and clear the accumulator.
  - If ZERO_SKIP=1 and (in_a==0 or in_b==0), go to DONE with acc=0.
  - Otherwise go to CALC with step=0.
- CALC: a 2-bit step counter selects the nibble pair presented to the 4x4 multiplier. Each step performs acc <= acc + (pp << shift).
  - step 0: a[3:0]*b[3:0], shift 0.
  - step 1: a[3:0]*b[7:4], shift 4.
  - step 2: a[7:4]*b[3:0], shift 4.
  - step 3: a[7:4]*b[7:4], shift 8.
  - After step 3, go to DONE.
- DONE: out_valid=1 and out_p=acc, both held stable until out_ready. On out_valid&out_ready, return to IDLE and increment op_count.
- Width rules:
  - Each partial product is 8 bits, zero-extended to 16 before shifting.
  - The accumulator is 16 bits. The maximum result, 65025, never overflows.
- op_count is modulo 256 and wraps 255 -> 0 silently.
- in_ready=1 only in IDLE. in_valid, in_a and in_b are ignored in CALC and DONE.
- Inputs are never accepted in the same cycle as an output handshake.
- out_ready is ignored when out_valid=0.
- Reset (any state, including mid-CALC) forces the following next cycle:
  - state=IDLE, step=0, acc=0, operand registers=0, op_count=0.
  - Outputs: in_ready=1, out_valid=0, out_p=0, busy=0.
  - A partially computed product is discarded and never presented.

## Timing
- Cycle 0: the input handshake occurs.
- Non-skip path:
  - CALC in cycles 1-4.
  - out_valid first high in cycle 5, so latency is 5 cycles.
  - Minimum throughput is one product per 6 cycles (DONE handshake in cycle 5, IDLE in cycle 6).
- Zero-skip path: out_valid high in cycle 1; a new input can be accepted in cycle 2 at the earliest.
- out_p is registered. No combinational path from in_* to out_* or from out_ready to in_ready.
- busy = (state != IDLE), registered-state-derived.

## Structure
- Shared package mult_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - constants OPERAND_W=8, NIBBLE_W=4, PRODUCT_W=16;
  - step-to-shift table (0, 4, 4, 8).
- One sub-module instance: array_mult_structural (4x4 -> 8-bit), fed by nibble muxes selected by step.
- Do not duplicate the multiplier. The controller owns only the muxes, the step counter, the accumulator, the FSM and the handshake.

## Test plan
- Reset: hold rst 2 cycles with random inputs.
  - Required: in_ready=1, out_valid=0, out_p=0, busy=0, op_count=0.
- Basic: in_a=13, in_b=11 handshake in cycle 0, out_ready=1.
  - Required: out_valid rises in cycle 5 with out_p=143; op_count=1 next cycle.
- Max and corner values: 255*255 -> 65025; 16*16 -> 256; 15*15 -> 225; 240*15 -> 3600. Each has 5-cycle latency.
- Zero skip:
  - ZERO_SKIP=1, 0*200: out_p=0 in cycle 1.
  - ZERO_SKIP=0, same operands: out_p=0 in cycle 5.
- Backpressure: 7*9 with out_ready low for 3 cycles after out_valid, while in_valid toggles with new operands.
  - Required: out_p=63 held stable throughout, in_ready=0, no new operands captured.
- Reset mid-operation: assert rst in cycle 2 of 100*100.
  - Required: IDLE next cycle, out_valid never rises for that pair.
  - Required: a following 3*5 yields 15 with normal latency.
- Counter wrap: 256 back-to-back products with out_ready=1 -> op_count returns to 0.
